// File: rtl/pe_ctrl_pkg.sv
// Shared types and sizing helpers for the PE array sequencer.
package pe_ctrl_pkg;

   localparam int unsigned CNT_W_DEFAULT = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      EXE    = 3'd2,
      STORE  = 3'd3,
      OUTPUT = 3'd4,
      DONE   = 3'd5
   } state_t;

   // Number of shift steps between a fmap entering the left edge and its psum row
   // leaving the bottom edge of the skewed array.
   function automatic int unsigned pipe_depth(input int unsigned rows, input int unsigned cols);
      return rows + cols - 1;
   endfunction

endpackage

// File: rtl/pe_array_ctrl_valid_pipe.sv
// Valid-bit shift register mirroring the skew of the PE array.
module pe_valid_pipe #(
   parameter int unsigned DEPTH = 16
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] pipe_q;

   // Advance one stage per array shift; clear wipes all in-flight tags.
   always_ff @(posedge clk) begin
      if (clr) begin
         pipe_q <= '0;
      end else if (en) begin
         pipe_q <= {pipe_q[DEPTH-2:0], din};
      end
   end

   assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/pe_array_ctrl.sv
// Sequencer for the systolic PE array: weight load, fmap streaming, drain, result tagging.
module pe_array_ctrl
   import pe_ctrl_pkg::*;
#(
   parameter int unsigned NUMBER_PE_ROW = 9,
   parameter int unsigned NUMBER_PE_COL = 8,
   parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
   input  logic                     i_clk,
   input  logic                     i_rest,
   input  logic                     start,
   input  logic [CNT_W-1:0]         i_num_pixels,
   input  logic                     weight_valid,
   output logic                     weight_ready,
   output logic [NUMBER_PE_COL-1:0] weight_en,
   input  logic                     fmap_valid,
   output logic                     fmap_ready,
   output logic [NUMBER_PE_ROW-1:0] i_left_en,
   output logic [NUMBER_PE_ROW-1:0] i_right_en,
   output logic                     psum_valid,
   input  logic                     psum_ready,
   output logic                     out_buf_rest,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned PIPE_D = pipe_depth(NUMBER_PE_ROW, NUMBER_PE_COL);
   localparam int unsigned COL_W  = (NUMBER_PE_COL > 1) ? $clog2(NUMBER_PE_COL) : 1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   n_q, in_cnt_q, out_cnt_q;
   logic [COL_W-1:0]   col_cnt_q;
   logic               out_ok, shift_en, start_acc, w_acc, f_acc, p_acc, pipe_din;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rest) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state, strobes and handshakes.
   always_comb begin
      state_d      = state_q;
      weight_ready = 1'b0;
      weight_en    = '0;
      fmap_ready   = 1'b0;
      shift_en     = 1'b0;
      out_buf_rest = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      start_acc    = 1'b0;
      w_acc        = 1'b0;
      f_acc        = 1'b0;
      out_ok       = ~psum_valid | psum_ready;
      p_acc        = psum_valid & psum_ready;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               start_acc = 1'b1;
               state_d   = LOAD;
            end
         end
         LOAD: begin
            weight_ready = 1'b1;
            if (weight_valid) begin
               w_acc     = 1'b1;
               weight_en = NUMBER_PE_COL'(1) << col_cnt_q;
               if (col_cnt_q == COL_W'(NUMBER_PE_COL - 1)) begin
                  state_d = (n_q == '0) ? OUTPUT : EXE;
               end
            end
         end
         EXE: begin
            fmap_ready = out_ok;
            if (fmap_valid && out_ok) begin
               f_acc    = 1'b1;
               shift_en = 1'b1;
               if (in_cnt_q == n_q - CNT_W'(1)) state_d = STORE;
            end
         end
         STORE: begin
            shift_en = out_ok;
            if (p_acc && (out_cnt_q == n_q - CNT_W'(1))) state_d = OUTPUT;
         end
         OUTPUT: begin
            out_buf_rest = 1'b1;
            state_d      = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Job length latch plus column, input and output counters.
   always_ff @(posedge i_clk) begin
      if (i_rest) begin
         n_q       <= '0;
         col_cnt_q <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         if (start_acc) begin
            n_q       <= i_num_pixels;
            col_cnt_q <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
         end
         if (w_acc) col_cnt_q <= col_cnt_q + COL_W'(1);
         if (f_acc) in_cnt_q  <= in_cnt_q + CNT_W'(1);
         if (p_acc) out_cnt_q <= out_cnt_q + CNT_W'(1);
      end
   end

   // Real fmap beats tag a 1; drain shifts in STORE tag a 0.
   assign pipe_din   = (state_q == EXE);
   assign i_left_en  = {NUMBER_PE_ROW{shift_en}};
   assign i_right_en = {NUMBER_PE_ROW{shift_en}};

   pe_valid_pipe #(
      .DEPTH (PIPE_D)
   ) u_valid_pipe (
      .clk  (i_clk),
      .clr  (i_rest | start_acc),
      .en   (shift_en),
      .din  (pipe_din),
      .dout (psum_valid)
   );

endmodule
